serial_arithmetic_unit: RTL and testbench
=========================================

Name: serial_arithmetic_unit

Overview:
- Digit-serial add/subtract engine; the next generation of the team's combinational add/sub ALU slice.
- Operands are N bits wide and are processed W bits per clock, LSB digit first, with the carry held in a register between digits.
- Adds carry-in/borrow-in chaining, signed overflow/zero/negative flags and a start/busy/done handshake.
- Sits beside the ALU datapath where area matters more than latency.

Parameters:
N, 8, operand/result width in bits; must be a multiple of W.
W, 4, digit width processed per cycle; 1 <= W <= N.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  request pulse; sampled only in IDLE.
a  input  N  operand A; sampled with start.
b  input  N  operand B; sampled with start.
op  input  2  00 add, 01 sub, 10 add with cin, 11 sub with cin; sampled with start.
cin  input  1  carry-in (ops 10/11); sampled with start.
busy  output  1  high while computing.
done  output  1  one-cycle pulse when results update.
out  output  N  result; held until next completion.
cout  output  1  carry out of MSB; for sub, 1 = no borrow.
overflow  output  1  two's-complement signed overflow.
zero  output  1  out == 0.
negative  output  1  out[N-1].

Behaviour:
- Decided: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset: state=IDLE; busy, done, out, cout, overflow, zero, negative all 0; internal registers cleared. Asserting rst_n low mid-operation aborts the operation immediately; no done pulse is produced.
- FSM states: IDLE, RUN.
  - IDLE -> RUN on a clk edge with start=1.
  - RUN stays for D = N/W edges, then returns to IDLE.
- Capture on the start edge:
  - A_reg <= a.
  - B_reg <= b for add ops; B_reg <= ~b for sub ops.
  - Carry register c: 0 for op 00; 1 for op 01; cin for ops 10 and 11.
  - Digit counter <= 0; busy <= 1.
- Each RUN edge k (k = 0..D-1):
  - Compute digit sum = A_reg[kW+:W] + B_reg[kW+:W] + c.
  - Write the low W bits into the result shift register; c <= the carry out of the digit.
  - On the final digit, also record the carry into bit N-1.
- Completion edge (last RUN edge, D edges after the start edge):
  - out, cout, overflow, zero and negative update together; done=1 for exactly one cycle; busy=0.
  - Arithmetic: out = (a + B' + c0) mod 2^N, where B' = b or ~b and c0 is the initial carry.
  - cout = carry out of bit N-1. overflow = carry into bit N-1 XOR carry out of bit N-1.
- Flags and out are updated only at completion and are stable otherwise, including during RUN.
- start while busy is ignored; there is no queueing. start on the completion edge is also ignored; a new start is accepted from the first IDLE cycle onward.
- Back-to-back throughput: one result per D+1 cycles.
- Inputs a, b, op and cin may change freely after the start edge.
- W = N is legal: D = 1, and done follows the start edge by one cycle.

Test Plan:
1. N=8, W=4, op=00, a=0x3C, b=0x15, start pulse -> busy high for 2 cycles; done at start edge +2; out=0x51, cout=0, overflow=0, zero=0, negative=0.
2. op=00, a=0x7F, b=0x01 -> out=0x80, overflow=1, negative=1, cout=0. Then a=0xFF, b=0x01 -> out=0x00, zero=1, cout=1, overflow=0.
3. op=01, a=0x10, b=0x20 -> out=0xF0, cout=0 (borrow), negative=1, overflow=0. Then op=11, cin=0, a=0x50, b=0x20 -> out=0x2F, cout=1.
4. op=10, cin=1, a=0x0F, b=0x00 -> out=0x10; this confirms the carry propagates across the digit boundary.
5. start held high for 4 cycles with a changing after the first edge -> exactly one computation using the first-edge operands; the second result begins only on a start seen in IDLE.
6. rst_n driven low for one cycle after the first RUN edge -> busy=0, done never pulses, all outputs 0. A following start with a=0x01, b=0x02, op=00 -> out=0x03.

Source files
------------

// File: rtl/serial_arithmetic_unit.sv
// Digit-serial add/subtract engine: N-bit operands processed W bits per clock, LSB digit first,
// with a registered carry between digits and a start/busy/done handshake.
module serial_arithmetic_unit #(
   parameter int unsigned N = 8,
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [1:0]   op,
   input  logic         cin,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] out,
   output logic         cout,
   output logic         overflow,
   output logic         zero,
   output logic         negative
);

   localparam int unsigned D    = N / W;
   localparam int unsigned CntW = (D > 1) ? $clog2(D) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(D - 1);

   typedef enum logic {StIdle, StRun} state_e;

   state_e          state_q, state_d;
   logic [N-1:0]    a_q, a_d;
   logic [N-1:0]    b_q, b_d;
   logic            c_q, c_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [N-1:0]    res_q, res_d;
   logic [N-1:0]    out_q, out_d;
   logic            cout_q, cout_d;
   logic            ovf_q, ovf_d;
   logic            zero_q, zero_d;
   logic            neg_q, neg_d;
   logic            done_q, done_d;

   logic [W:0]      digit_sum;
   logic            carry_msb;
   logic [N-1:0]    res_next;

   // Operands shift right each digit, so the active digit always sits in the low W bits.
   assign digit_sum = {1'b0, a_q[W-1:0]} + {1'b0, b_q[W-1:0]} + (W + 1)'(c_q);
   // Carry into the digit's top bit; on the final digit this is the carry into bit N-1.
   assign carry_msb = digit_sum[W-1] ^ a_q[W-1] ^ b_q[W-1];

   // Result digits enter at the top and move down, so the first digit ends at the bottom.
   generate
      if (W < N) begin : g_multi_digit
         assign res_next = {digit_sum[W-1:0], res_q[N-1:W]};
      end else begin : g_single_digit
         assign res_next = digit_sum[W-1:0];
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      out_d   = out_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;
      neg_d   = neg_q;
      done_d  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               a_d     = a;
               b_d     = op[0] ? ~b : b;
               c_d     = op[1] ? cin : op[0];
               cnt_d   = '0;
               res_d   = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            a_d   = a_q >> W;
            b_d   = b_q >> W;
            c_d   = digit_sum[W];
            res_d = res_next;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LastCnt) begin
               state_d = StIdle;
               out_d   = res_next;
               cout_d  = digit_sum[W];
               ovf_d   = carry_msb ^ digit_sum[W];
               zero_d  = (res_next == '0);
               neg_d   = res_next[N-1];
               done_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= 1'b0;
         cnt_q   <= '0;
         res_q   <= '0;
         out_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
         neg_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         out_q   <= out_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
         neg_q   <= neg_d;
         done_q  <= done_d;
      end
   end

   assign busy     = (state_q == StRun);
   assign done     = done_q;
   assign out      = out_q;
   assign cout     = cout_q;
   assign overflow = ovf_q;
   assign zero     = zero_q;
   assign negative = neg_q;

endmodule

// File: tb/tb_serial_arithmetic_unit.sv
// Bench for serial_arithmetic_unit: directed cases, abort-by-reset, and a cycle-level
// scoreboard driven by random operands and start patterns.
module tb_serial_arithmetic_unit;

   localparam int N = 8;
   localparam int W = 4;
   localparam int D = N / W;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [N-1:0] a, b;
   logic [1:0]   op;
   logic         cin;
   logic         busy, done, cout, overflow, zero, negative;
   logic [N-1:0] out;

   int errors = 0;
   int checks = 0;

   // Expected held outputs, tracked across tests.
   logic [N-1:0] e_out;
   logic         e_cout, e_ovf, e_zero, e_neg;

   serial_arithmetic_unit #(.N(N), .W(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .a        (a),
      .b        (b),
      .op       (op),
      .cin      (cin),
      .busy     (busy),
      .done     (done),
      .out      (out),
      .cout     (cout),
      .overflow (overflow),
      .zero     (zero),
      .negative (negative)
   );

   always #5 clk = ~clk;

   // Returns {overflow, cout, out} from plain N+1 bit arithmetic and operand signs.
   function automatic logic [N+1:0] model(input logic [N-1:0] av, input logic [N-1:0] bv,
                                          input logic [1:0] opv, input logic cinv);
      logic [N-1:0] bb;
      logic         c0;
      logic [N:0]   full;
      logic         ovf;
      bb   = opv[0] ? ~bv : bv;
      c0   = opv[1] ? cinv : opv[0];
      full = {1'b0, av} + {1'b0, bb} + {{N{1'b0}}, c0};
      ovf  = (av[N-1] == bb[N-1]) && (full[N-1] != av[N-1]);
      return {ovf, full};
   endfunction

   task automatic set_expected(input logic [N+1:0] r);
      {e_ovf, e_cout, e_out} = r;
      e_zero = (e_out == '0);
      e_neg  = e_out[N-1];
   endtask

   // Issues one operation and waits (bounded) for done; lat = negedges from start edge to done.
   task automatic run_op(input logic [N-1:0] av, input logic [N-1:0] bv, input logic [1:0] opv,
                         input logic cinv, output int lat, output int busy_n, output bit stable);
      logic [N-1:0] out0;
      @(negedge clk);
      out0  = out;
      a     = av;
      b     = bv;
      op    = opv;
      cin   = cinv;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start  = 1'b0;
      a      = N'($urandom);
      b      = N'($urandom);
      op     = 2'($urandom);
      cin    = 1'($urandom);
      lat    = -1;
      busy_n = 0;
      stable = 1'b1;
      for (int i = 1; i <= 50; i++) begin
         if (busy) busy_n++;
         if (done) begin
            lat = i;
            break;
         end
         if (out !== out0) stable = 1'b0;
         @(negedge clk);
      end
      set_expected(model(av, bv, opv, cinv));
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      a = '0; b = '0; op = '0; cin = 1'b0;
      e_out = '0; e_cout = 1'b0; e_ovf = 1'b0; e_zero = 1'b0; e_neg = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, done, out, cout, overflow, zero, negative} !== '0) begin
         errors++;
         $display("FAIL reset_held: got %b required all zero",
                  {busy, done, out, cout, overflow, zero, negative});
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, done, out, cout, overflow, zero, negative} !== '0) begin
         errors++;
         $display("FAIL reset_release: got %b required all zero",
                  {busy, done, out, cout, overflow, zero, negative});
      end
   endtask

   task automatic test_directed();
      // a, b, op, cin, out, cout, overflow
      logic [N-1:0] ta  [8] = '{8'h3C, 8'h7F, 8'hFF, 8'h10, 8'h50, 8'h0F, 8'h80, 8'h80};
      logic [N-1:0] tb  [8] = '{8'h15, 8'h01, 8'h01, 8'h20, 8'h20, 8'h00, 8'h01, 8'h80};
      logic [1:0]   top [8] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b11, 2'b10, 2'b01, 2'b00};
      logic         tci [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [N-1:0] xo  [8] = '{8'h51, 8'h80, 8'h00, 8'hF0, 8'h2F, 8'h10, 8'h7F, 8'h00};
      logic         xc  [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      logic         xv  [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      int lat, busy_n;
      bit stable;
      logic [N+3:0] got, req;
      for (int i = 0; i < 8; i++) begin
         run_op(ta[i], tb[i], top[i], tci[i], lat, busy_n, stable);
         checks++;
         if (lat != D + 1 || busy_n != D) begin
            errors++;
            $display("FAIL directed_timing[%0d]: got latency %0d busy %0d required %0d / %0d",
                     i, lat, busy_n, D + 1, D);
         end
         got = {out, cout, overflow, zero, negative};
         req = {xo[i], xc[i], xv[i], xo[i] == '0, xo[i][N-1]};
         checks++;
         if (got !== req) begin
            errors++;
            $display("FAIL directed_result[%0d]: got out=%h c=%b v=%b z=%b n=%b required %h %b %b %b %b",
                     i, out, cout, overflow, zero, negative,
                     req[N+3:4], req[3], req[2], req[1], req[0]);
         end
         checks++;
         if (!stable) begin
            errors++;
            $display("FAIL directed_out_stable[%0d]: out changed during RUN, required held", i);
         end
         @(negedge clk);
         checks++;
         if (done !== 1'b0) begin
            errors++;
            $display("FAIL directed_done_pulse[%0d]: got done=%b one cycle later required 0",
                     i, done);
         end
      end
   endtask

   task automatic test_abort();
      int lat, busy_n;
      bit stable;
      @(negedge clk);
      a = 8'h3C; b = 8'h15; op = 2'b00; cin = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, out, cout, overflow, zero, negative} !== '0) begin
         errors++;
         $display("FAIL abort_clear: got %b required all zero",
                  {busy, done, out, cout, overflow, zero, negative});
      end
      @(negedge clk);
      rst_n = 1'b1;
      e_out = '0; e_cout = 1'b0; e_ovf = 1'b0; e_zero = 1'b0; e_neg = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || busy !== 1'b0 || out !== '0) begin
            errors++;
            $display("FAIL abort_quiet[%0d]: got done=%b busy=%b out=%h required 0 0 00",
                     i, done, busy, out);
         end
      end
      run_op(8'h01, 8'h02, 2'b00, 1'b0, lat, busy_n, stable);
      checks++;
      if (out !== 8'h03 || lat != D + 1) begin
         errors++;
         $display("FAIL abort_restart: got out=%h latency %0d required 03 latency %0d",
                  out, lat, D + 1);
      end
   endtask

   // Cycle-level scoreboard. mode 0: random start, 1: start held 4 cycles, 2: start always high.
   task automatic run_sched(input int ncyc, input int mode, input string name);
      int           free_at = 0;
      int           done_at = -100;
      logic [N+1:0] pend = '0;
      logic         start_v, exp_done, exp_busy;
      logic [N+3:0] got, req;
      @(negedge clk);
      for (int e = 0; e < ncyc; e++) begin
         if (e >= ncyc - D - 2) start_v = 1'b0;
         else if (mode == 0)    start_v = ($urandom_range(0, 1) == 1);
         else if (mode == 1)    start_v = (e < 4);
         else                   start_v = 1'b1;
         a     = N'($urandom);
         b     = N'($urandom);
         op    = 2'($urandom);
         cin   = 1'($urandom);
         start = start_v;
         if (start_v && e >= free_at) begin
            pend    = model(a, b, op, cin);
            done_at = e + D;
            free_at = e + D + 1;
         end
         @(posedge clk);
         @(negedge clk);
         exp_done = (e == done_at);
         exp_busy = (e >= done_at - D) && (e < done_at);
         if (exp_done) set_expected(pend);
         checks++;
         if (done !== exp_done) begin
            errors++;
            $display("FAIL %s_done[%0d]: got %b required %b", name, e, done, exp_done);
         end
         checks++;
         if (busy !== exp_busy) begin
            errors++;
            $display("FAIL %s_busy[%0d]: got %b required %b", name, e, busy, exp_busy);
         end
         got = {out, cout, overflow, zero, negative};
         req = {e_out, e_cout, e_ovf, e_zero, e_neg};
         checks++;
         if (got !== req) begin
            errors++;
            $display("FAIL %s_result[%0d]: got %h required %h", name, e, got, req);
         end
      end
      start = 1'b0;
   endtask

   task automatic test_start_held();
      run_sched(12, 1, "start_held");
   endtask

   task automatic test_back_to_back();
      run_sched(20, 2, "back_to_back");
   endtask

   task automatic test_random();
      run_sched(300, 0, "random");
   endtask

   initial begin
      test_reset();
      test_directed();
      test_abort();
      test_start_held();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
